// File: rtl/nios_switch_pkg.sv
// ============================================================================
//  Module      : nios_switch_pkg
//  Description : Shared definitions for the switch PIO interrupt master.
//                Includes responder register offsets, FSM states, the bus
//                access type and a saturating counter helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package nios_switch_pkg;

    // Register offsets in the switch PIO responder.
    localparam logic [1:0] SW_ADDR_DATA    = 2'd0;
    localparam logic [1:0] SW_ADDR_IRQMASK = 2'd2;

    // Master sequencing states.
    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_ARM          = 4'd1,
        ST_WAIT_IRQ     = 4'd2,
        ST_MASK_OFF     = 4'd3,
        ST_RD           = 4'd4,
        ST_RD_WAIT      = 4'd5,
        ST_POLL_WAIT    = 4'd6,
        ST_POLL_RD      = 4'd7,
        ST_POLL_RD_WAIT = 4'd8,
        ST_DISARM       = 4'd9
    } sw_state_e;

    // Avalon access type.
    typedef enum logic {
        ACC_RD = 1'b0,
        ACC_WR = 1'b1
    } av_access_e;

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nios_switch_bus_seq.sv
// ============================================================================
//  Module      : nios_switch_bus_seq
//  Description : Single-access Avalon-MM sequencer. A request cycle drives a
//                one-cycle chipselect. For reads it counts RD_LATENCY cycles
//                and flags the cycle in which readdata is valid.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module nios_switch_bus_seq
    import nios_switch_pkg::*;
#(
    parameter int DATA_W     = 1,
    parameter int RD_LATENCY = 1
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_i,
    input  av_access_e        acc_i,
    input  logic [1:0]        addr_i,
    input  logic [31:0]       wdata_i,
    output logic              rd_done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        av_address_o,
    output logic              av_chipselect_o,
    output logic              av_write_n_o,
    output logic [31:0]       av_writedata_o,
    input  logic [31:0]       av_readdata_i
);

    localparam int LAT_W = $clog2(RD_LATENCY + 1);

    logic [1:0]       addr_q,  addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             pend_q,  pend_d;
    logic [LAT_W-1:0] lat_q,   lat_d;
    logic             w_is_wr;

    assign w_is_wr = req_i && (acc_i == ACC_WR);

    // The request is presented on the bus in the same cycle; between
    // accesses the last address/writedata are held and write_n idles high.
    assign av_chipselect_o = req_i;
    assign av_write_n_o    = !w_is_wr;
    assign av_address_o    = req_i   ? addr_i  : addr_q;
    assign av_writedata_o  = w_is_wr ? wdata_i : wdata_q;

    assign rd_done_o = pend_q && (lat_q == LAT_W'(RD_LATENCY));
    assign rdata_o   = av_readdata_i[DATA_W-1:0];

    generate
        if (DATA_W < 32) begin : g_unused_rdata
            logic w_unused_rdata;
            assign w_unused_rdata = ^av_readdata_i[31:DATA_W];
        end
    endgenerate

    // Next-state for held bus fields and the read-latency counter.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pend_d  = pend_q;
        lat_d   = lat_q;
        if (req_i) begin
            addr_d = addr_i;
        end
        if (w_is_wr) begin
            wdata_d = wdata_i;
        end
        if (req_i && (acc_i == ACC_RD)) begin
            pend_d = 1'b1;
            lat_d  = LAT_W'(1);
        end else if (pend_q) begin
            if (lat_q == LAT_W'(RD_LATENCY)) begin
                pend_d = 1'b0;
                lat_d  = '0;
            end else begin
                lat_d = lat_q + LAT_W'(1);
            end
        end
    end

    // State registers; reset abandons any pending read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            pend_q  <= 1'b0;
            lat_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
            lat_q   <= lat_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/nios_switch_irq_master.sv
// ============================================================================
//  Module      : nios_switch_irq_master
//  Description : Hardware stand-in for the switch ISR. Arms the PIO irq mask,
//                on interrupt masks it, reads the switch value, emits a
//                timestamped event on a valid/ready port, polls for release
//                and re-arms.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module nios_switch_irq_master
    import nios_switch_pkg::*;
#(
    parameter int                DATA_W      = 1,
    parameter int                TS_W        = 32,
    parameter int                POLL_CYCLES = 1000,
    parameter int                RD_LATENCY  = 1,
    parameter logic [DATA_W-1:0] MASK_INIT   = DATA_W'(1)
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [1:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [31:0]       av_writedata,
    input  logic [31:0]       av_readdata,
    input  logic              av_irq,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_data,
    output logic [TS_W-1:0]   evt_ts,
    output logic [15:0]       evt_dropped
);

    localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    sw_state_e         state_q, state_d;
    logic [TS_W-1:0]   ts_q;
    logic [TS_W-1:0]   irq_ts_q, irq_ts_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic              evt_valid_q, evt_valid_d;
    logic [DATA_W-1:0] evt_data_q, evt_data_d;
    logic [TS_W-1:0]   evt_ts_q, evt_ts_d;
    logic [15:0]       evt_dropped_q, evt_dropped_d;

    logic              w_req;
    av_access_e        w_acc;
    logic [1:0]        w_addr;
    logic [31:0]       w_wdata;
    logic              w_rd_done;
    logic [DATA_W-1:0] w_rdata;
    logic              w_load;
    logic              w_drop;

    nios_switch_bus_seq #(
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY)
    ) u_bus_seq (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_i           (w_req),
        .acc_i           (w_acc),
        .addr_i          (w_addr),
        .wdata_i         (w_wdata),
        .rd_done_o       (w_rd_done),
        .rdata_o         (w_rdata),
        .av_address_o    (av_address),
        .av_chipselect_o (av_chipselect),
        .av_write_n_o    (av_write_n),
        .av_writedata_o  (av_writedata),
        .av_readdata_i   (av_readdata)
    );

    // Sequencing FSM: next state, bus requests and event load/drop strobes.
    // The emit decision is taken in the readdata-valid cycle of RD_WAIT so
    // the event appears on the edge right after the data returns.
    always_comb begin
        state_d  = state_q;
        irq_ts_d = irq_ts_q;
        poll_d   = '0;
        w_req    = 1'b0;
        w_acc    = ACC_RD;
        w_addr   = SW_ADDR_DATA;
        w_wdata  = '0;
        w_load   = 1'b0;
        w_drop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_ARM;
            end
            ST_ARM: begin
                w_req   = 1'b1;
                w_acc   = ACC_WR;
                w_addr  = SW_ADDR_IRQMASK;
                w_wdata = 32'(MASK_INIT);
                state_d = ST_WAIT_IRQ;
            end
            ST_WAIT_IRQ: begin
                if (!enable) begin
                    state_d = ST_DISARM;
                end else if (av_irq) begin
                    irq_ts_d = ts_q;
                    state_d  = ST_MASK_OFF;
                end
            end
            ST_MASK_OFF: begin
                w_req   = 1'b1;
                w_acc   = ACC_WR;
                w_addr  = SW_ADDR_IRQMASK;
                state_d = enable ? ST_RD : ST_DISARM;
            end
            ST_RD: begin
                w_req   = 1'b1;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (w_rd_done) begin
                    if (!enable) begin
                        state_d = ST_DISARM;
                    end else if (w_rdata == '0) begin
                        // Spurious interrupt: nothing pressed, re-arm at once.
                        state_d = ST_ARM;
                    end else begin
                        w_load  = !evt_valid_q;
                        w_drop  = evt_valid_q;
                        state_d = ST_POLL_WAIT;
                    end
                end
            end
            ST_POLL_WAIT: begin
                if (!enable) begin
                    state_d = ST_DISARM;
                end else if (poll_q == POLL_W'(POLL_CYCLES - 1)) begin
                    state_d = ST_POLL_RD;
                end else begin
                    poll_d = poll_q + POLL_W'(1);
                end
            end
            ST_POLL_RD: begin
                w_req   = 1'b1;
                state_d = ST_POLL_RD_WAIT;
            end
            ST_POLL_RD_WAIT: begin
                if (w_rd_done) begin
                    if (!enable)             state_d = ST_DISARM;
                    else if (w_rdata != '0)  state_d = ST_POLL_WAIT;
                    else                     state_d = ST_ARM;
                end
            end
            ST_DISARM: begin
                w_req   = 1'b1;
                w_acc   = ACC_WR;
                w_addr  = SW_ADDR_IRQMASK;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register: loads only when empty, clears after a ready cycle.
    always_comb begin
        evt_valid_d   = evt_valid_q;
        evt_data_d    = evt_data_q;
        evt_ts_d      = evt_ts_q;
        evt_dropped_d = evt_dropped_q;
        if (w_load) begin
            evt_valid_d = 1'b1;
            evt_data_d  = w_rdata;
            evt_ts_d    = irq_ts_q;
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end
        if (w_drop) begin
            evt_dropped_d = sat_inc16(evt_dropped_q);
        end
    end

    // State, timestamp, poll counter and output register flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ts_q          <= '0;
            irq_ts_q      <= '0;
            poll_q        <= '0;
            evt_valid_q   <= 1'b0;
            evt_data_q    <= '0;
            evt_ts_q      <= '0;
            evt_dropped_q <= '0;
        end else begin
            state_q       <= state_d;
            ts_q          <= ts_q + TS_W'(1);
            irq_ts_q      <= irq_ts_d;
            poll_q        <= poll_d;
            evt_valid_q   <= evt_valid_d;
            evt_data_q    <= evt_data_d;
            evt_ts_q      <= evt_ts_d;
            evt_dropped_q <= evt_dropped_d;
        end
    end

    assign evt_valid   = evt_valid_q;
    assign evt_data    = evt_data_q;
    assign evt_ts      = evt_ts_q;
    assign evt_dropped = evt_dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_nios_switch_irq_master.sv
// ============================================================================
//  Module      : tb_nios_switch_irq_master
//  Description : Directed self-checking bench. Two instances share clock and
//                reset: A (RD_LATENCY=1, TS_W=32, POLL_CYCLES=1000) and
//                B (RD_LATENCY=3, TS_W=4, POLL_CYCLES=4), each with a small
//                switch PIO responder model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nios_switch_irq_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // ---------------- instance A ----------------
    logic        a_en, a_cs, a_wn, a_irq, a_ev, a_rdy, a_sw, a_mask, a_rv;
    logic [1:0]  a_addr;
    logic [31:0] a_wd, a_rd, a_rdv, a_ts;
    logic [0:0]  a_evd;
    logic [15:0] a_drop;

    nios_switch_irq_master #(
        .DATA_W (1), .TS_W (32), .POLL_CYCLES (1000), .RD_LATENCY (1), .MASK_INIT (1'b1)
    ) u_dut_a (
        .clk (clk), .reset_n (reset_n), .enable (a_en),
        .av_address (a_addr), .av_chipselect (a_cs), .av_write_n (a_wn),
        .av_writedata (a_wd), .av_readdata (a_rd), .av_irq (a_irq),
        .evt_valid (a_ev), .evt_ready (a_rdy), .evt_data (a_evd),
        .evt_ts (a_ts), .evt_dropped (a_drop)
    );

    // Responder A: mask register, level irq, readdata one cycle after read.
    // Outside a valid read slot readdata carries the inverted switch so a
    // mistimed sample is visible.
    always @(posedge clk) begin
        if (!reset_n) begin
            a_mask <= 1'b0;
            a_rv   <= 1'b0;
            a_rdv  <= '0;
        end else begin
            if (a_cs && !a_wn && a_addr == 2'd2) a_mask <= a_wd[0];
            a_rv  <= a_cs && a_wn;
            a_rdv <= (a_addr == 2'd0) ? {31'd0, a_sw} : {31'd0, a_mask};
        end
    end
    assign a_rd  = a_rv ? a_rdv : {31'd0, ~a_sw};
    assign a_irq = a_sw & a_mask;

    // ---------------- instance B ----------------
    logic        b_en, b_cs, b_wn, b_irq, b_ev, b_rdy, b_sw, b_mask;
    logic [1:0]  b_addr;
    logic [31:0] b_wd, b_rd;
    logic [3:0]  b_ts;
    logic [0:0]  b_evd;
    logic [15:0] b_drop;
    logic [2:0]  b_rv;
    logic [31:0] b_rdv [3];

    nios_switch_irq_master #(
        .DATA_W (1), .TS_W (4), .POLL_CYCLES (4), .RD_LATENCY (3), .MASK_INIT (1'b1)
    ) u_dut_b (
        .clk (clk), .reset_n (reset_n), .enable (b_en),
        .av_address (b_addr), .av_chipselect (b_cs), .av_write_n (b_wn),
        .av_writedata (b_wd), .av_readdata (b_rd), .av_irq (b_irq),
        .evt_valid (b_ev), .evt_ready (b_rdy), .evt_data (b_evd),
        .evt_ts (b_ts), .evt_dropped (b_drop)
    );

    // Responder B: readdata three cycles after the read.
    always @(posedge clk) begin
        if (!reset_n) begin
            b_mask   <= 1'b0;
            b_rv     <= '0;
            b_rdv[0] <= '0;
            b_rdv[1] <= '0;
            b_rdv[2] <= '0;
        end else begin
            if (b_cs && !b_wn && b_addr == 2'd2) b_mask <= b_wd[0];
            b_rv     <= {b_rv[1:0], b_cs && b_wn};
            b_rdv[0] <= (b_addr == 2'd0) ? {31'd0, b_sw} : {31'd0, b_mask};
            b_rdv[1] <= b_rdv[0];
            b_rdv[2] <= b_rdv[1];
        end
    end
    assign b_rd  = b_rv[2] ? b_rdv[2] : {31'd0, ~b_sw};
    assign b_irq = b_sw & b_mask;

    // ---------------- reference time and traffic counters ----------------
    logic [31:0] cyc;
    int a_wr_cnt = 0, a_rd_cnt = 0, a_evt_cnt = 0;

    always @(posedge clk) begin
        if (!reset_n) cyc <= '0;
        else          cyc <= cyc + 32'd1;
        if (a_cs && !a_wn) a_wr_cnt <= a_wr_cnt + 1;
        if (a_cs &&  a_wn) a_rd_cnt <= a_rd_cnt + 1;
        if (a_ev && a_rdy) a_evt_cnt <= a_evt_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] ts_exp, ts1;
        logic [3:0]  bts_exp;
        int wr0, rd0, e0;

        reset_n = 1'b0;
        a_en = 1'b0; a_sw = 1'b0; a_rdy = 1'b1;
        b_en = 1'b0; b_sw = 1'b0; b_rdy = 1'b1;
        step(3);

        // Reset values
        check_eq("rst_bus", {a_cs, a_wn, a_addr, a_wd}, {1'b0, 1'b1, 2'd0, 32'd0});
        check_eq("rst_evt", {a_ev, a_evd, a_drop}, '0);
        check_eq("rst_ts", a_ts, 32'd0);

        // 1: enable -> single mask write of 1, then quiet
        reset_n = 1'b1;
        a_en    = 1'b1;
        step(1);
        check_eq("arm_wr", {a_cs, a_wn, a_addr, a_wd}, {1'b1, 1'b0, 2'd2, 32'd1});
        wr0 = a_wr_cnt; rd0 = a_rd_cnt;
        step(20);
        check_eq("arm_wr_count", 64'(a_wr_cnt - wr0), 64'd1);
        check_eq("arm_rd_count", 64'(a_rd_cnt - rd0), 64'd0);
        check_eq("arm_mask", a_mask, 1'b1);

        // 2: press with ready=1
        e0     = a_evt_cnt;
        a_sw   = 1'b1;
        ts_exp = cyc;
        step(1);
        check_eq("maskoff_wr", {a_cs, a_wn, a_addr, a_wd}, {1'b1, 1'b0, 2'd2, 32'd0});
        step(1);
        check_eq("rd_issue", {a_cs, a_wn, a_addr}, {1'b1, 1'b1, 2'd0});
        step(1);
        check_eq("evt_early", a_ev, 1'b0);
        step(1);
        check_eq("evt_valid", a_ev, 1'b1);
        check_eq("evt_data", a_evd, 1'b1);
        check_eq("evt_ts", a_ts, ts_exp);
        step(1);
        check_eq("evt_one_cycle", a_ev, 1'b0);

        // 3: hold until 5000 cycles after press, then release
        rd0 = a_rd_cnt;
        step(4995);
        check_eq("hold_polls", 64'(a_rd_cnt - rd0), 64'd4);
        a_sw = 1'b0;
        wr0  = a_wr_cnt;
        step(100);
        check_eq("release_polls", 64'(a_rd_cnt - rd0), 64'd5);
        check_eq("rearm_wr", 64'(a_wr_cnt - wr0), 64'd1);
        check_eq("rearm_mask", a_mask, 1'b1);
        check_eq("hold_one_evt", 64'(a_evt_cnt - e0), 64'd1);

        // 4: ready=0, two presses -> first held, one drop
        a_rdy = 1'b0;
        e0    = a_evt_cnt;
        a_sw  = 1'b1;
        ts1   = cyc;
        step(10);
        a_sw  = 1'b0;
        step(1010);
        check_eq("t4_rearm1", a_mask, 1'b1);
        a_sw  = 1'b1;
        step(10);
        a_sw  = 1'b0;
        step(1010);
        check_eq("t4_hold_valid", a_ev, 1'b1);
        check_eq("t4_hold_data", a_evd, 1'b1);
        check_eq("t4_hold_ts", a_ts, ts1);
        check_eq("t4_dropped", a_drop, 16'd1);
        check_eq("t4_rearm2", a_mask, 1'b1);
        a_rdy = 1'b1;
        step(1);
        check_eq("t4_accept", a_ev, 1'b0);
        check_eq("t4_evt_cnt", 64'(a_evt_cnt - e0), 64'd1);

        // 5: enable drops during RD_WAIT
        e0 = a_evt_cnt; wr0 = a_wr_cnt; rd0 = a_rd_cnt;
        a_sw = 1'b1;
        step(3);
        a_en = 1'b0;
        check_eq("t5_rdwait_bus", a_cs, 1'b0);
        step(1);
        check_eq("t5_disarm", {a_cs, a_wn, a_addr, a_wd}, {1'b1, 1'b0, 2'd2, 32'd0});
        step(1);
        check_eq("t5_after_disarm", a_cs, 1'b0);
        a_sw = 1'b0;
        step(50);
        check_eq("t5_no_evt", 64'(a_evt_cnt - e0), 64'd0);
        check_eq("t5_ev_low", a_ev, 1'b0);
        check_eq("t5_wr_count", 64'(a_wr_cnt - wr0), 64'd2);
        check_eq("t5_rd_count", 64'(a_rd_cnt - rd0), 64'd1);
        check_eq("t5_mask", a_mask, 1'b0);

        // 5b: reset in the middle of the arming write
        a_en = 1'b1;
        step(1);
        check_eq("t5_arm_again", {a_cs, a_wn, a_addr}, {1'b1, 1'b0, 2'd2});
        reset_n = 1'b0;
        step(1);
        check_eq("t5_rst_bus", {a_cs, a_wn, a_addr, a_wd}, {1'b0, 1'b1, 2'd0, 32'd0});
        check_eq("t5_rst_evt", {a_ev, a_evd, a_drop}, '0);
        check_eq("t5_rst_ts", a_ts, 32'd0);
        a_en = 1'b0;
        step(2);

        // 6: instance B, read latency 3 and 4-bit timestamp wrap
        reset_n = 1'b1;
        b_en    = 1'b1;
        step(10);
        check_eq("t6_armed", b_mask, 1'b1);
        for (int i = 0; i < 40 && cyc[3:0] != 4'd15; i++) step(1);
        bts_exp = cyc[3:0];
        check_eq("t6_align15", bts_exp, 4'd15);
        b_sw = 1'b1;
        step(2);
        check_eq("t6_rd_issue", {b_cs, b_wn, b_addr}, {1'b1, 1'b1, 2'd0});
        step(3);
        check_eq("t6_evt_early", b_ev, 1'b0);
        step(1);
        check_eq("t6_evt_valid", b_ev, 1'b1);
        check_eq("t6_evt_data", b_evd, 1'b1);
        check_eq("t6_evt_ts15", b_ts, 4'd15);
        step(1);
        check_eq("t6_evt_clear", b_ev, 1'b0);
        b_sw = 1'b0;
        step(30);
        check_eq("t6_rearm", b_mask, 1'b1);
        for (int i = 0; i < 40 && cyc[3:0] != 4'd0; i++) step(1);
        bts_exp = cyc[3:0];
        check_eq("t6_align0", bts_exp, 4'd0);
        b_sw = 1'b1;
        step(6);
        check_eq("t6_evt2_valid", b_ev, 1'b1);
        check_eq("t6_evt2_ts0", b_ts, 4'd0);
        b_sw = 1'b0;
        step(30);
        check_eq("t6_no_drop", b_drop, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
